demux4_reg: RTL and testbench

- Registered 1-to-4 demultiplexer with valid/ready handshakes on the input and on each of the four outputs.
- Routes one input beat to one of four destination channels, selected by a 2-bit select.
- Each channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits in the datapath wherever one producer feeds several consumers. It is the distribution counterpart of the mux2/mux4 selection logic.

---
 rtl/demux4_reg_pkg.sv | 14 +
 rtl/demux4_reg_slot.sv | 44 ++++
 rtl/demux4_reg.sv | 53 +++++
 tb/tb_demux4_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
package demux4_reg_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux4_reg_slot.sv
// One-entry valid/ready holding register; a write wins over a same-cycle drain,
// so a full slot that is being drained can be refilled without a bubble.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end else if (valid_q && rd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid      = valid_q;
  assign data       = data_q;
  assign can_accept = ~valid_q | rd_ready;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer: select decode, in_ready mux and busy around four slots.
module demux4_reg
  import demux4_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             busy
);

  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] can_accept;
  logic [NUM_CH-1:0] slot_valid;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic              accept;

  // in_ready depends only on the addressed slot, never on in_valid.
  assign in_ready = rst_n & can_accept[in_sel];
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept ? sel_onehot(in_sel) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en[g]),
      .wr_data    (in_data),
      .rd_ready   (out_ready[g]),
      .valid      (slot_valid[g]),
      .data       (slot_data[g]),
      .can_accept (can_accept[g])
    );
  end

  assign out_valid = slot_valid;
  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign busy      = |slot_valid;

endmodule

// File: tb/tb_demux4_reg.sv
// Self-checking bench for demux4_reg against a behavioural per-channel model.
module tb_demux4_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: each channel is a one-deep mailbox (full flag + content).
  logic        m_full [4];
  logic [31:0] m_val  [4];

  demux4_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dout(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic m_ready();
    return rst_n && (!m_full[in_sel] || out_ready[in_sel]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_val[i]  = '0;
    end
  endtask

  // Advance one clock; the mailbox model takes/delivers beats at the same edge.
  task automatic tick();
    logic take;
    take = in_valid && m_ready();
    for (int i = 0; i < 4; i++) begin
      if (take && int'(in_sel) == i) begin
        m_full[i] = 1'b1;
        m_val[i]  = in_data;
      end else if (m_full[i] && out_ready[i]) begin
        m_full[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1234_5678; out_ready = 4'b0000;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout(i) !== 32'h0) begin errors++; $display("FAIL reset_data%0d got=%h exp=0", i, dout(i)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_release_valid got=%b exp=0000", out_valid); end
  endtask

  task automatic test_basic_route();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEAD_BEEF; out_ready = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL basic_out_valid got=%b exp=0100", out_valid); end
    checks++; if (out_data2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_data2 got=%h exp=deadbeef", out_data2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if ({out_data0, out_data1, out_data3} !== 96'h0) begin errors++; $display("FAIL basic_others got=%h %h %h exp=0", out_data0, out_data1, out_data3); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_sel = 2'd2; in_data = $urandom; out_ready = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_data2 !== 32'hDEAD_BEEF || out_valid !== 4'b0100) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=deadbeef/0100", c, out_data2, out_valid);
      end
    end
    in_sel = 2'd1; in_data = 32'h0000_0011;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_isolation_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL bp_isolation_valid got=%b exp=0110", out_valid); end
    checks++; if (out_data1 !== 32'h11) begin errors++; $display("FAIL bp_isolation_data1 got=%h exp=11", out_data1); end
  endtask

  task automatic test_drain_refill();
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL dr_flush got=%b exp=0000", out_valid); end
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h1; out_ready = 4'b0000;
    tick();
    out_ready = 4'b0001; in_data = 32'h2;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dr_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    checks++; if (out_valid[0] !== 1'b1 || out_data0 !== 32'h2) begin
      errors++; $display("FAIL dr_refill got=%b/%h exp=1/00000002", out_valid[0], out_data0);
    end
  endtask

  task automatic test_stream();
    logic [31:0] got [4][8];
    int          cnt [4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
    for (int k = 0; k < 18; k++) begin
      in_valid = (k < 16);
      in_sel   = 2'(k % 4);
      in_data  = 32'(k);
      #1;
      if (k < 16) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat=%0d got=%b exp=1", k, in_ready); end
      end
      if (k == 16) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy_last got=%b exp=1", busy); end
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (out_valid[ch] && cnt[ch] < 8) begin
          got[ch][cnt[ch]] = dout(ch);
          cnt[ch]++;
        end
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_drop got=%b exp=0", busy); end
    for (int ch = 0; ch < 4; ch++) begin
      checks++; if (cnt[ch] != 4) begin errors++; $display("FAIL stream_count ch=%0d got=%0d exp=4", ch, cnt[ch]); end
      for (int j = 0; j < 4 && j < cnt[ch]; j++) begin
        checks++; if (got[ch][j] !== 32'(4 * j + ch)) begin
          errors++; $display("FAIL stream_order ch=%0d idx=%0d got=%0d exp=%0d", ch, j, got[ch][j], 4 * j + ch);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 4'b0000;
    in_sel = 2'd1; in_data = 32'hAAAA_0001; tick();
    in_sel = 2'd3; in_data = 32'hAAAA_0003; tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL ar_loaded got=%b exp=1010", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL ar_immediate got=%b busy=%b exp=0000 busy=0", out_valid, busy);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 4'b0000 || out_data1 !== 32'h0 || out_data3 !== 32'h0) begin
      errors++; $display("FAIL ar_no_stale got=%b %h %h exp=0000 0 0", out_valid, out_data1, out_data3);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom);
      #1;
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, m_ready()); end
      checks++; if (out_valid !== m_valid_vec() || busy !== (|m_valid_vec())) begin
        errors++; $display("FAIL rand_valid cyc=%0d got=%b/%b exp=%b", c, out_valid, busy, m_valid_vec());
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (m_full[ch]) begin
          checks++; if (dout(ch) !== m_val[ch]) begin
            errors++; $display("FAIL rand_data cyc=%0d ch=%0d got=%h exp=%h", c, ch, dout(ch), m_val[ch]);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_backpressure();
    test_drain_refill();
    test_stream();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
